xor_parity_accumulator: RTL

XOR_PARITY_ACCUMULATOR -- requirements
Module: xor_parity_accumulator

---
 rtl/xor_parity_accumulator_pkg.sv | 10 +
 rtl/xor_parity_accumulator_xor_reduce.sv | 9 +
 rtl/xor_parity_accumulator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/xor_parity_accumulator_pkg.sv
// Shared definitions for the XOR parity accumulator: FSM encoding and counter sizing.
package xor_parity_accumulator_pkg;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned ERR_SAT = 255;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/xor_parity_accumulator_xor_reduce.sv
// N-input XOR reduction tree; combinational parity of one word.
module xor_reduce #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_data,
  output logic         o_parity
);
  assign o_parity = ^i_data;
endmodule

// File: rtl/xor_parity_accumulator.sv
// Per-word parity plus framed parity accumulation with optional compare and saturating error count.
module xor_parity_accumulator
  import xor_parity_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ODD_MODE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               frame_start,
  input  logic               check_en,
  input  logic               rx_parity,
  output logic               out_valid,
  output logic               word_even,
  output logic               word_odd,
  output logic               frame_done,
  output logic               frame_parity,
  output logic               parity_err,
  output logic [COUNT_W-1:0] word_count,
  output logic [COUNT_W-1:0] err_count
);
  localparam logic [COUNT_W-1:0] LEN_C = COUNT_W'(FRAME_LEN);
  localparam logic [COUNT_W-1:0] SAT_C = COUNT_W'(ERR_SAT);
  localparam logic               ODD_C = 1'(ODD_MODE);

  state_t             r_state;
  logic               r_acc;
  logic [COUNT_W-1:0] r_count;
  logic               r_out_valid;
  logic               r_word_even;
  logic               r_word_odd;
  logic               r_frame_done;
  logic               r_frame_parity;
  logic               r_parity_err;
  logic [COUNT_W-1:0] r_err_count;

  state_t             w_state_nxt;
  logic               w_acc_nxt;
  logic [COUNT_W-1:0] w_count_nxt;
  logic               w_out_valid_nxt;
  logic               w_word_even_nxt;
  logic               w_word_odd_nxt;
  logic               w_frame_done_nxt;
  logic               w_frame_parity_nxt;
  logic               w_parity_err_nxt;
  logic [COUNT_W-1:0] w_err_count_nxt;
  logic               w_word_par;
  logic               w_acc_new;
  logic               w_fpar_new;
  logic               w_perr_new;

  xor_reduce #(.N(WIDTH)) u_xor_reduce (
    .i_data   (in_data),
    .o_parity (w_word_par)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, frame accumulation and output next-values.
  always_comb begin
    w_state_nxt        = r_state;
    w_acc_nxt          = r_acc;
    w_count_nxt        = r_count;
    w_out_valid_nxt    = 1'b0;
    w_word_even_nxt    = r_word_even;
    w_word_odd_nxt     = r_word_odd;
    w_frame_done_nxt   = 1'b0;
    w_frame_parity_nxt = r_frame_parity;
    w_parity_err_nxt   = r_parity_err;
    w_err_count_nxt    = r_err_count;
    w_acc_new          = r_acc ^ w_word_par;
    w_fpar_new         = w_acc_new ^ ODD_C;
    w_perr_new         = check_en & (w_fpar_new != rx_parity);

    if (in_valid) begin
      w_out_valid_nxt = 1'b1;
      w_word_even_nxt = w_word_par;
      w_word_odd_nxt  = ~w_word_par;
    end

    if (frame_start) begin
      // Open frame is dropped silently; a qualifying word opens the new one.
      if (in_valid) begin
        w_state_nxt = ACCUM;
        w_acc_nxt   = w_word_par;
        w_count_nxt = COUNT_W'(1);
      end else begin
        w_state_nxt = IDLE;
        w_acc_nxt   = 1'b0;
        w_count_nxt = '0;
      end
    end else if (in_valid) begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ACCUM;
          w_acc_nxt   = w_word_par;
          w_count_nxt = COUNT_W'(1);
        end
        ACCUM: begin
          if (r_count + COUNT_W'(1) == LEN_C) begin
            w_state_nxt        = IDLE;
            w_acc_nxt          = 1'b0;
            w_count_nxt        = '0;
            w_frame_done_nxt   = 1'b1;
            w_frame_parity_nxt = w_fpar_new;
            w_parity_err_nxt   = w_perr_new;
            if (w_perr_new && (r_err_count != SAT_C)) begin
              w_err_count_nxt = r_err_count + COUNT_W'(1);
            end
          end else begin
            w_acc_nxt   = w_acc_new;
            w_count_nxt = r_count + COUNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = 1'b0;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc          <= 1'b0;
      r_count        <= '0;
      r_out_valid    <= 1'b0;
      r_word_even    <= 1'b0;
      r_word_odd     <= 1'b1;
      r_frame_done   <= 1'b0;
      r_frame_parity <= ODD_C;
      r_parity_err   <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_acc          <= w_acc_nxt;
      r_count        <= w_count_nxt;
      r_out_valid    <= w_out_valid_nxt;
      r_word_even    <= w_word_even_nxt;
      r_word_odd     <= w_word_odd_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_frame_parity <= w_frame_parity_nxt;
      r_parity_err   <= w_parity_err_nxt;
      r_err_count    <= w_err_count_nxt;
    end
  end

  assign out_valid    = r_out_valid;
  assign word_even    = r_word_even;
  assign word_odd     = r_word_odd;
  assign frame_done   = r_frame_done;
  assign frame_parity = r_frame_parity;
  assign parity_err   = r_parity_err;
  assign word_count   = r_count;
  assign err_count    = r_err_count;
endmodule
